ex_operand_forward_ctrl: RTL
============================

// Module: ex_operand_forward_ctrl
// PURPOSE
//  Control-side counterpart of the EX-stage ALU operand muxes: generates and registers the
//  select codes they consume (input2Select, fwdSelA, fwdSelB). Tracks in-flight destination
//  registers for the EX/MEM/WB stages, detects RAW and load-use hazards, stalls ID one cycle
//  on load-use, and inserts EX bubbles. Sits on the ID->EX boundary beside the ID/EX register.
// PARAMETERS
//  REG_ADDR_W   5   register-index width (x0..x31)
//  FWD_X0       0   1 = allow forwarding when rd==0 (debug only); 0 = x0 never forwarded
// PORTS
//  clk          in   1           single clock, rising edge
//  rstN         in   1           reset, asynchronous, active-low
//  idValid      in   1           decoded instruction in ID is valid
//  idRs1        in   REG_ADDR_W  ID source register 1
//  idRs2        in   REG_ADDR_W  ID source register 2
//  idUsesRs1    in   1           ID instruction reads rs1
//  idUsesRs2    in   1           ID instruction reads rs2 (ALU operand or store data)
//  idRd         in   REG_ADDR_W  ID destination register
//  idRegWrite   in   1           ID instruction writes rd
//  idMemRead    in   1           ID instruction is a load
//  idAluSrc     in   2           decoded operand-2 source: 00 reg, 01 imm, 10 const 1, 11 const 0
//  flush        in   1           branch/jump taken in EX: kill instruction entering EX
//  input2Select out  2           registered select to ALU operand-2 mux (same encoding as idAluSrc)
//  fwdSelA      out  2           registered rs1 forward select: 00 regfile, 01 MEM result, 10 WB result
//  fwdSelB      out  2           registered rs2 forward select, same encoding
//  stall        out  1           hold PC and IF/ID this cycle (combinational)
//  exBubble     out  1           registered: EX stage holds a bubble
// BEHAVIOUR
//  Reset (rstN=0, async): EX/MEM/WB entries invalid; input2Select=11, fwdSelA=fwdSelB=00,
//   exBubble=1, state=RUN; stall=0 while in reset.
//  Scoreboard entry per stage {valid, rd, regWrite, memRead}. Every clock: WB<=MEM, MEM<=EX.
//   EX<=ID fields if idValid & ~stall & ~flush; else EX<=bubble (valid=0).
//  Forward compare (against current EX -> becomes MEM, current MEM -> becomes WB):
//   match = entry.valid & entry.regWrite & entry.rd==rs & (rs!=0 | FWD_X0) & uses_rs.
//   EX match -> 01; else MEM match -> 10; else 00 (newest wins). Registered on the ID->EX load.
//  Load-use hazard: EX.valid & EX.memRead & EX match on rs1 or rs2 & idValid.
//  FSM: RUN: hazard & ~flush -> stall=1, go LDSTALL. LDSTALL: stall=0, go RUN unconditionally
//   (load is now in MEM; next compare yields 10). Max one stall cycle per load.
//  Bubble load: input2Select<=11, fwdSelA/B<=00, exBubble<=1. Valid load: input2Select<=idAluSrc,
//   exBubble<=0.
//  flush has priority over stall: bubble inserted, stall=0, state<=RUN.
//  idValid=0: treated as bubble, no hazard, no stall.
//  Reset mid-stall: all state cleared, stall drops immediately (async).
//  Latency: selects valid in the cycle the instruction occupies EX (1 clock after ID).
// STRUCTURE
//  Package pipeline_ctrl_pkg: stage_entry_t struct, fwd_sel_t enum {FWD_REG, FWD_MEM, FWD_WB},
//   alu_src_t enum {SRC_REG, SRC_IMM, SRC_ONE, SRC_ZERO}, hzd_state_t enum {RUN, LDSTALL}.
//  One sub-module: hazard_match (combinational entry-vs-rs comparator, instanced 4x).
// TESTING
//  1 Reset: rstN=0 mid-stream -> input2Select=11, fwdSel=00, exBubble=1, stall=0 same cycle.
//  2 add x5,x1,x2 then sub x6,x5,x3 -> fwdSelA=01 for sub in EX, no stall.
//  3 add x5 ; nop ; or x7,x5,x5 -> fwdSelA=fwdSelB=10.
//  4 lw x5 ; add x6,x5,x1 -> stall=1 exactly one cycle, exBubble=1, then fwdSelA=10.
//  5 add x0,x1,x2 ; sub x3,x0,x4 -> fwdSelA=00 (x0 never forwarded).
//  6 lw x5 with flush=1 in hazard cycle -> stall=0, exBubble=1, state RUN;
//    addi x8,x9,4 -> input2Select=01, fwdSelB=00.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the ID->EX operand-forwarding control: scoreboard entries and select codes.
package pipeline_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    SRC_REG  = 2'b00,
    SRC_IMM  = 2'b01,
    SRC_ONE  = 2'b10,
    SRC_ZERO = 2'b11
  } alu_src_t;

  typedef enum logic {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } hzd_state_t;

  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational compare of one in-flight scoreboard entry against one ID source register.
module hazard_match
  import pipeline_ctrl_pkg::*;
#(
  parameter bit FWD_X0 = 1'b0
) (
  input  stage_entry_t        i_entry,
  input  logic [RegAddrW-1:0] i_rs,
  input  logic                i_uses_rs,
  output logic                o_match
);

  logic w_rs_ok;

  // x0 is hardwired zero, so a write to it must never be forwarded unless debugging.
  assign w_rs_ok = (i_rs != '0) || FWD_X0;

  assign o_match = i_entry.valid && i_entry.reg_write && (i_entry.rd == i_rs) &&
                   w_rs_ok && i_uses_rs;

endmodule

// File: rtl/ex_operand_forward_ctrl.sv
// Generates registered ALU operand-2 and forwarding selects for EX, and stalls ID on load-use.
module ex_operand_forward_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter bit          FWD_X0     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic [REG_ADDR_W-1:0] idRd,
  input  logic                  idRegWrite,
  input  logic                  idMemRead,
  input  logic [1:0]            idAluSrc,
  input  logic                  flush,
  output logic [1:0]            input2Select,
  output logic [1:0]            fwdSelA,
  output logic [1:0]            fwdSelB,
  output logic                  stall,
  output logic                  exBubble
);

  hzd_state_t   r_state, w_state_d;
  stage_entry_t r_ex, r_mem, r_wb, w_ex_d;
  alu_src_t     r_input2_select;
  fwd_sel_t     r_fwd_sel_a, r_fwd_sel_b, w_fwd_a, w_fwd_b;
  logic         r_ex_bubble;

  logic w_ex_match_a, w_ex_match_b, w_mem_match_a, w_mem_match_b;
  logic w_hazard, w_stall, w_load;

  hazard_match #(.FWD_X0(FWD_X0)) u_match_ex_a (
    .i_entry(r_ex), .i_rs(idRs1), .i_uses_rs(idUsesRs1), .o_match(w_ex_match_a)
  );
  hazard_match #(.FWD_X0(FWD_X0)) u_match_ex_b (
    .i_entry(r_ex), .i_rs(idRs2), .i_uses_rs(idUsesRs2), .o_match(w_ex_match_b)
  );
  hazard_match #(.FWD_X0(FWD_X0)) u_match_mem_a (
    .i_entry(r_mem), .i_rs(idRs1), .i_uses_rs(idUsesRs1), .o_match(w_mem_match_a)
  );
  hazard_match #(.FWD_X0(FWD_X0)) u_match_mem_b (
    .i_entry(r_mem), .i_rs(idRs2), .i_uses_rs(idUsesRs2), .o_match(w_mem_match_b)
  );

  assign w_hazard = r_ex.valid && r_ex.mem_read && (w_ex_match_a || w_ex_match_b) && idValid;

  // Flush wins over a load-use stall: the consumer is being killed anyway.
  always_comb begin
    w_state_d = r_state;
    w_stall   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_hazard && !flush) begin
          w_stall   = 1'b1;
          w_state_d = LDSTALL;
        end
      end
      LDSTALL: w_state_d = RUN;
      default: w_state_d = RUN;
    endcase
  end

  assign w_load = idValid && !w_stall && !flush;

  // Newest producer wins: the instruction now in EX will be in MEM when the consumer is in EX.
  always_comb begin
    w_fwd_a = FWD_REG;
    w_fwd_b = FWD_REG;
    if (w_ex_match_a) w_fwd_a = FWD_MEM;
    else if (w_mem_match_a) w_fwd_a = FWD_WB;
    if (w_ex_match_b) w_fwd_b = FWD_MEM;
    else if (w_mem_match_b) w_fwd_b = FWD_WB;
  end

  always_comb begin
    w_ex_d           = '0;
    w_ex_d.valid     = w_load;
    w_ex_d.rd        = idRd;
    w_ex_d.reg_write = idRegWrite && w_load;
    w_ex_d.mem_read  = idMemRead && w_load;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state         <= RUN;
      r_ex            <= '0;
      r_mem           <= '0;
      r_wb            <= '0;
      r_input2_select <= SRC_ZERO;
      r_fwd_sel_a     <= FWD_REG;
      r_fwd_sel_b     <= FWD_REG;
      r_ex_bubble     <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_ex_d;
      if (w_load) begin
        r_input2_select <= alu_src_t'(idAluSrc);
        r_fwd_sel_a     <= w_fwd_a;
        r_fwd_sel_b     <= w_fwd_b;
        r_ex_bubble     <= 1'b0;
      end else begin
        r_input2_select <= SRC_ZERO;
        r_fwd_sel_a     <= FWD_REG;
        r_fwd_sel_b     <= FWD_REG;
        r_ex_bubble     <= 1'b1;
      end
    end
  end

  // WB is kept only for debug visibility; it must always trail MEM by one cycle.
  a_wb_follows_mem: assert property (@(posedge clk) disable iff (!rstN) r_wb == $past(r_mem));

  assign stall        = w_stall;
  assign input2Select = r_input2_select;
  assign fwdSelA      = r_fwd_sel_a;
  assign fwdSelB      = r_fwd_sel_b;
  assign exBubble     = r_ex_bubble;

endmodule
